// File: rtl/pipe_pkg.sv
// Types and helpers shared by the pipeline hazard controller and its counters.
package pipe_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_PERF   = 2;
   localparam int PERF_STALL = 0;
   localparam int PERF_FLUSH = 1;

   typedef enum logic [1:0] {
      S_RUN,
      S_MEM_WAIT,
      S_ERROR
   } hz_state_t;

   typedef struct packed {
      logic pc_enb;
      logic ifid_enb;
      logic idex_enb;
      logic exmem_enb;
      logic memwb_enb;
      logic ifid_flush;
      logic idex_flush;
   } pipe_ctrl_t;

   // x0 is hard-wired to zero, so a load targeting it never creates a dependency.
   function automatic logic rs_depends(input logic used,
                                       input logic [REG_ADDR_W-1:0] rs,
                                       input logic [REG_ADDR_W-1:0] rd);
      return used && (rd != '0) && (rs == rd);
   endfunction

endpackage

// File: rtl/perf_counter.sv
// Free-running event counter with enable; wraps modulo 2^WIDTH.
module perf_counter #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_enb,
   output logic [WIDTH-1:0] o_count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         count_reg <= '0;
      end else if (i_enb) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign o_count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush control: memory-wait stalls with timeout, EX redirect
// flushes and load-use bubbles, plus stall/flush performance counters.
module hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
   input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
   input  logic                  i_id_rs1_used,
   input  logic                  i_id_rs2_used,
   input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
   input  logic                  i_ex_is_load,
   input  logic                  i_ex_redirect,
   input  logic                  i_mem_req,
   input  logic                  i_mem_ack,
   output logic                  o_pc_enb,
   output logic                  o_ifid_enb,
   output logic                  o_idex_enb,
   output logic                  o_exmem_enb,
   output logic                  o_memwb_enb,
   output logic                  o_ifid_flush,
   output logic                  o_idex_flush,
   output logic                  o_mem_timeout,
   output logic [CNT_WIDTH-1:0]  o_stall_cnt,
   output logic [CNT_WIDTH-1:0]  o_flush_cnt
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   hz_state_t         state_reg;
   logic [WAIT_W-1:0] wait_cnt_reg;
   logic [WAIT_W-1:0] wait_cnt_next;
   logic              mem_timeout_reg;

   logic              mem_stall;
   logic              load_use;
   logic              flush_event;
   pipe_ctrl_t        ctrl;

   logic [NUM_PERF-1:0]  perf_enb;
   logic [CNT_WIDTH-1:0] perf_count [NUM_PERF];

   // ------------------------------------------------------------------
   // Hazard decisions (combinational, zero latency)
   // ------------------------------------------------------------------
   always_comb begin
      mem_stall = 1'b0;
      unique case (state_reg)
         S_RUN:      mem_stall = i_mem_req && !i_mem_ack;
         S_MEM_WAIT: mem_stall = !i_mem_ack;
         S_ERROR:    mem_stall = 1'b1;
         default:    mem_stall = 1'b1;
      endcase
   end

   assign load_use = i_ex_is_load &&
                     (rs_depends(i_id_rs1_used, i_id_rs1_addr, i_ex_rd_addr) ||
                      rs_depends(i_id_rs2_used, i_id_rs2_addr, i_ex_rd_addr));

   // A redirect held through a memory stall is only acted on once EX moves.
   assign flush_event = !mem_stall && i_ex_redirect;

   always_comb begin
      ctrl = '{pc_enb: 1'b1, ifid_enb: 1'b1, idex_enb: 1'b1,
               exmem_enb: 1'b1, memwb_enb: 1'b1,
               ifid_flush: 1'b0, idex_flush: 1'b0};
      if (mem_stall) begin
         ctrl = '0;
      end else if (i_ex_redirect) begin
         ctrl.ifid_flush = 1'b1;
         ctrl.idex_flush = 1'b1;
      end else if (load_use) begin
         ctrl.pc_enb     = 1'b0;
         ctrl.ifid_enb   = 1'b0;
         ctrl.idex_flush = 1'b1;
      end
   end

   assign o_pc_enb     = ctrl.pc_enb;
   assign o_ifid_enb   = ctrl.ifid_enb;
   assign o_idex_enb   = ctrl.idex_enb;
   assign o_exmem_enb  = ctrl.exmem_enb;
   assign o_memwb_enb  = ctrl.memwb_enb;
   assign o_ifid_flush = ctrl.ifid_flush;
   assign o_idex_flush = ctrl.idex_flush;

   // ------------------------------------------------------------------
   // Memory-wait FSM with saturating timeout counter
   // ------------------------------------------------------------------
   assign wait_cnt_next = (wait_cnt_reg == WAIT_LIMIT) ? wait_cnt_reg
                                                       : wait_cnt_reg + WAIT_W'(1);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_reg       <= S_RUN;
         wait_cnt_reg    <= '0;
         mem_timeout_reg <= 1'b0;
      end else begin
         unique case (state_reg)
            S_RUN: begin
               if (i_mem_req && !i_mem_ack) begin
                  state_reg    <= S_MEM_WAIT;
                  wait_cnt_reg <= '0;
               end
            end
            S_MEM_WAIT: begin
               if (i_mem_ack) begin
                  state_reg <= S_RUN;
               end else begin
                  wait_cnt_reg <= wait_cnt_next;
                  if (wait_cnt_next == WAIT_LIMIT) begin
                     state_reg       <= S_ERROR;
                     mem_timeout_reg <= 1'b1;
                  end
               end
            end
            S_ERROR: begin
               state_reg       <= S_ERROR;
               mem_timeout_reg <= 1'b1;
            end
            default: begin
               state_reg       <= S_ERROR;
               mem_timeout_reg <= 1'b1;
            end
         endcase
      end
   end

   assign o_mem_timeout = mem_timeout_reg;

   // ------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------
   assign perf_enb[PERF_STALL] = !ctrl.pc_enb;
   assign perf_enb[PERF_FLUSH] = flush_event;

   generate
      for (genvar gi = 0; gi < NUM_PERF; gi++) begin : g_perf
         perf_counter #(
            .WIDTH (CNT_WIDTH)
         ) u_perf_counter (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .i_enb   (perf_enb[gi]),
            .o_count (perf_count[gi])
         );
      end
   endgenerate

   assign o_stall_cnt = perf_count[PERF_STALL];
   assign o_flush_cnt = perf_count[PERF_FLUSH];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, redirect, memory wait, timeout, wrap, reset.
module tb_hazard_ctrl;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [4:0] i_id_rs1_addr, i_id_rs2_addr, i_ex_rd_addr;
   logic       i_id_rs1_used, i_id_rs2_used, i_ex_is_load, i_ex_redirect;
   logic       i_mem_req, i_mem_ack;
   logic       o_pc_enb, o_ifid_enb, o_idex_enb, o_exmem_enb, o_memwb_enb;
   logic       o_ifid_flush, o_idex_flush, o_mem_timeout;
   logic [7:0] o_stall_cnt, o_flush_cnt;
   logic [6:0] ctrl;

   int tests = 0;
   int fails = 0;

   // {pc, ifid, idex, exmem, memwb, ifid_flush, idex_flush}
   localparam logic [6:0] NORMAL = 7'b1111100;
   localparam logic [6:0] LU     = 7'b0011101;
   localparam logic [6:0] RED    = 7'b1111111;
   localparam logic [6:0] STALL  = 7'b0000000;

   always #5 i_clk = ~i_clk;

   hazard_ctrl #(
      .MEM_TIMEOUT (4),
      .CNT_WIDTH   (8)
   ) dut (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_id_rs1_addr (i_id_rs1_addr),
      .i_id_rs2_addr (i_id_rs2_addr),
      .i_id_rs1_used (i_id_rs1_used),
      .i_id_rs2_used (i_id_rs2_used),
      .i_ex_rd_addr  (i_ex_rd_addr),
      .i_ex_is_load  (i_ex_is_load),
      .i_ex_redirect (i_ex_redirect),
      .i_mem_req     (i_mem_req),
      .i_mem_ack     (i_mem_ack),
      .o_pc_enb      (o_pc_enb),
      .o_ifid_enb    (o_ifid_enb),
      .o_idex_enb    (o_idex_enb),
      .o_exmem_enb   (o_exmem_enb),
      .o_memwb_enb   (o_memwb_enb),
      .o_ifid_flush  (o_ifid_flush),
      .o_idex_flush  (o_idex_flush),
      .o_mem_timeout (o_mem_timeout),
      .o_stall_cnt   (o_stall_cnt),
      .o_flush_cnt   (o_flush_cnt)
   );

   assign ctrl = {o_pc_enb, o_ifid_enb, o_idex_enb, o_exmem_enb, o_memwb_enb,
                  o_ifid_flush, o_idex_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %-14s observed=%0h", tag, obs);
   endtask

   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr();
      i_id_rs1_addr = '0; i_id_rs2_addr = '0; i_ex_rd_addr = '0;
      i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
      i_ex_is_load = 1'b0; i_ex_redirect = 1'b0;
      i_mem_req = 1'b0; i_mem_ack = 1'b0;
   endtask

   initial begin
      i_reset = 1'b0;
      clr();
      #2;
      chk("rst_ctrl", 32'(ctrl), 32'(NORMAL));
      chk("rst_stall_cnt", 32'(o_stall_cnt), 32'd0);
      chk("rst_flush_cnt", 32'(o_flush_cnt), 32'd0);
      chk("rst_timeout", 32'(o_mem_timeout), 32'd0);
      i_mem_req = 1'b1;
      #1 chk("rst_req_stall", 32'(ctrl), 32'(STALL));
      i_mem_req = 1'b0;
      cyc();
      i_reset = 1'b1;

      // load-use on rs1, then the bubble has gone through
      i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1;
      #3 chk("lu_rs1", 32'(ctrl), 32'(LU));
      cyc(); clr();
      #3 chk("lu_next", 32'(ctrl), 32'(NORMAL));
      chk("lu_stall_cnt", 32'(o_stall_cnt), 32'd1);

      // load-use on rs2 only
      i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd7; i_id_rs2_addr = 5'd7; i_id_rs2_used = 1'b1;
      i_id_rs1_addr = 5'd7; i_id_rs1_used = 1'b0;
      #3 chk("lu_rs2", 32'(ctrl), 32'(LU));
      cyc(); clr();

      // load to x0, and matching but unused operands
      i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd0; i_id_rs1_used = 1'b1; i_id_rs2_used = 1'b1;
      #3 chk("lu_x0", 32'(ctrl), 32'(NORMAL));
      cyc();
      i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_rs2_addr = 5'd5;
      i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
      #3 chk("lu_unused", 32'(ctrl), 32'(NORMAL));
      cyc(); clr();
      chk("lu2_stall_cnt", 32'(o_stall_cnt), 32'd2);

      // redirect wins over load-use
      i_ex_is_load = 1'b1; i_ex_rd_addr = 5'd5; i_id_rs1_addr = 5'd5; i_id_rs1_used = 1'b1;
      i_ex_redirect = 1'b1;
      #3 chk("red_lu", 32'(ctrl), 32'(RED));
      cyc(); clr();
      chk("red_flush_cnt", 32'(o_flush_cnt), 32'd1);
      chk("red_stall_cnt", 32'(o_stall_cnt), 32'd2);

      // memory wait: 3 un-acked cycles then ack
      i_mem_req = 1'b1;
      #3 chk("mw_req", 32'(ctrl), 32'(STALL));
      cyc(); i_mem_req = 1'b0;
      #3 chk("mw_wait1", 32'(ctrl), 32'(STALL));
      cyc();
      #3 chk("mw_wait2", 32'(ctrl), 32'(STALL));
      cyc(); i_mem_ack = 1'b1;
      #3 chk("mw_ack", 32'(ctrl), 32'(NORMAL));
      cyc(); i_mem_ack = 1'b0;
      #3 chk("mw_back_run", 32'(ctrl), 32'(NORMAL));
      chk("mw_stall_cnt", 32'(o_stall_cnt), 32'd5);

      // request acked in the same cycle
      i_mem_req = 1'b1; i_mem_ack = 1'b1;
      #3 chk("mw_same_ack", 32'(ctrl), 32'(NORMAL));
      cyc(); clr();
      #3 chk("mw_same_after", 32'(ctrl), 32'(NORMAL));
      chk("mw_same_cnt", 32'(o_stall_cnt), 32'd5);

      // redirect held through a memory stall
      i_ex_redirect = 1'b1; i_mem_req = 1'b1;
      #3 chk("rs_req", 32'(ctrl), 32'(STALL));
      cyc(); i_mem_req = 1'b0;
      #3 chk("rs_wait", 32'(ctrl), 32'(STALL));
      cyc();
      chk("rs_flush_hold", 32'(o_flush_cnt), 32'd1);
      i_mem_ack = 1'b1;
      #3 chk("rs_ack", 32'(ctrl), 32'(RED));
      cyc(); clr();
      #3 chk("rs_after", 32'(ctrl), 32'(NORMAL));
      chk("rs_flush_cnt", 32'(o_flush_cnt), 32'd2);
      chk("rs_stall_cnt", 32'(o_stall_cnt), 32'd7);

      // timeout: request cycle, then 4 un-acked wait cycles
      i_mem_req = 1'b1;
      #3 chk("to_req", 32'(ctrl), 32'(STALL));
      cyc(); i_mem_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #3 chk("to_wait", 32'(ctrl), 32'(STALL));
         chk("to_not_yet", 32'(o_mem_timeout), 32'd0);
         cyc();
      end
      #3 chk("to_before", 32'(o_mem_timeout), 32'd0);
      cyc();
      chk("to_set", 32'(o_mem_timeout), 32'd1);
      chk("to_stall_cnt", 32'(o_stall_cnt), 32'd12);
      i_mem_ack = 1'b1; i_ex_redirect = 1'b1;
      #3 chk("err_sticky", 32'(ctrl), 32'(STALL));
      cyc();
      chk("err_stall_cnt", 32'(o_stall_cnt), 32'd13);
      chk("err_flush_cnt", 32'(o_flush_cnt), 32'd2);
      repeat (250) cyc();
      chk("wrap_stall_cnt", 32'(o_stall_cnt), 32'd7);
      chk("err_still", 32'(o_mem_timeout), 32'd1);

      // asynchronous reset clears the error and counters without a clock edge
      clr();
      i_reset = 1'b0;
      #1 chk("arst_timeout", 32'(o_mem_timeout), 32'd0);
      chk("arst_stall_cnt", 32'(o_stall_cnt), 32'd0);
      chk("arst_flush_cnt", 32'(o_flush_cnt), 32'd0);
      chk("arst_ctrl", 32'(ctrl), 32'(NORMAL));
      #2 i_reset = 1'b1;
      cyc();
      chk("post_rst_ctrl", 32'(ctrl), 32'(NORMAL));
      chk("post_rst_cnt", 32'(o_stall_cnt), 32'd0);

      // reset in the middle of a wait returns to run
      i_mem_req = 1'b1;
      #3 chk("mr_req", 32'(ctrl), 32'(STALL));
      cyc(); i_mem_req = 1'b0;
      #3 chk("mr_wait", 32'(ctrl), 32'(STALL));
      cyc();
      chk("mr_stall_cnt", 32'(o_stall_cnt), 32'd2);
      i_reset = 1'b0;
      #1 chk("mr_rst_cnt", 32'(o_stall_cnt), 32'd0);
      #2 i_reset = 1'b1;
      #1 chk("mr_run", 32'(ctrl), 32'(NORMAL));
      cyc();
      chk("mr_final_cnt", 32'(o_stall_cnt), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
